// File: rtl/formula_isqrt_sum_pipe.sv
// Pipelined sum of per-channel integer square roots.
// FORMULA_ISQRT_SUM_IN_REG_EN adds an input register stage.
module formula_isqrt_sum_pipe #(
  parameter int N_ARGS = 3,
  parameter int ARG_W  = 32,
  localparam int SQ_W    = ARG_W / 2,
  localparam int ADD_LVL = $clog2(N_ARGS),
  localparam int RES_W   = SQ_W + ADD_LVL
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arg_vld,
  input  logic [N_ARGS*ARG_W-1:0] args,
  output logic                    res_vld,
  output logic [RES_W-1:0]        res,
  output logic                    busy
);

  localparam int NV    = SQ_W + ADD_LVL + 1;
  localparam int REM_W = SQ_W + 2;

  function automatic int cnt(int l);
    return (N_ARGS + (1 << l) - 1) >> l;
  endfunction

  logic                    in_vld;
  logic [N_ARGS*ARG_W-1:0] in_args;
  logic [NV-1:0]           vp_q;

`ifdef FORMULA_ISQRT_SUM_IN_REG_EN
  logic                    in_vld_q;
  logic [N_ARGS*ARG_W-1:0] in_args_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) in_vld_q <= 1'b0;
    else      in_vld_q <= arg_vld;
  end

  always_ff @(posedge clk) begin
    if (arg_vld) in_args_q <= args;
  end

  assign in_vld  = in_vld_q;
  assign in_args = in_args_q;
  assign busy    = (|vp_q) | in_vld_q;
`else
  assign in_vld  = arg_vld;
  assign in_args = args;
  assign busy    = |vp_q;
`endif

  // One valid bit per stage: isqrt, adder levels, output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vp_q <= '0;
    else      vp_q <= (vp_q << 1) | NV'(in_vld);
  end

  for (genvar s = 0; s < SQ_W; s++) begin : stg
    localparam int IW = ARG_W - 2 * s;
    logic v_in;

    if (s == 0) begin : g_v
      assign v_in = in_vld;
    end else begin : g_v
      assign v_in = vp_q[s-1];
    end

    for (genvar c = 0; c < N_ARGS; c++) begin : ch
      logic [REM_W-1:0] rem_i;
      logic [REM_W-1:0] rem_sh;
      logic [REM_W-1:0] trial;
      logic [SQ_W-1:0]  root_i;
      logic [SQ_W-1:0]  root_q;
      logic [IW-1:0]    rad_i;
      logic             ge;

      if (s == 0) begin : g_in
        assign rem_i  = '0;
        assign root_i = '0;
        assign rad_i  = in_args[c*ARG_W +: ARG_W];
      end else begin : g_in
        assign rem_i  = stg[s-1].ch[c].g_nx.rem_q;
        assign root_i = stg[s-1].ch[c].root_q;
        assign rad_i  = stg[s-1].ch[c].g_nx.rad_q;
      end

      assign rem_sh = (rem_i << 2) | REM_W'(rad_i[IW-1 -: 2]);
      assign trial  = {root_i, 2'b01};
      assign ge     = rem_sh >= trial;

      always_ff @(posedge clk) begin
        if (v_in) root_q <= (root_i << 1) | SQ_W'(ge);
      end

      if (s < SQ_W - 1) begin : g_nx
        logic [REM_W-1:0] rem_q;
        logic [IW-3:0]    rad_q;

        always_ff @(posedge clk) begin
          if (v_in) begin
            rem_q <= ge ? rem_sh - trial : rem_sh;
            rad_q <= rad_i[IW-3:0];
          end
        end
      end
    end
  end

  logic [RES_W-1:0] tree_sum;

  if (ADD_LVL == 0) begin : g_notree
    assign tree_sum = RES_W'(stg[SQ_W-1].ch[0].root_q);
  end else begin : g_tree
    for (genvar l = 1; l <= ADD_LVL; l++) begin : lvl
      localparam int NI = cnt(l - 1);
      localparam int NO = cnt(l);

      for (genvar i = 0; i < NI; i++) begin : g_op
        logic [RES_W-1:0] op;
        if (l == 1) begin : g_src
          assign op = RES_W'(stg[SQ_W-1].ch[i].root_q);
        end else begin : g_src
          assign op = lvl[l-1].nd[i].sum_q;
        end
      end

      // Odd leftover operand is registered unchanged.
      for (genvar o = 0; o < NO; o++) begin : nd
        logic [RES_W-1:0] sum_q;
        if (2 * o + 1 < NI) begin : g_add
          always_ff @(posedge clk) begin
            if (vp_q[SQ_W+l-2])
              sum_q <= g_op[2*o].op + g_op[2*o+1].op;
          end
        end else begin : g_pass
          always_ff @(posedge clk) begin
            if (vp_q[SQ_W+l-2]) sum_q <= g_op[2*o].op;
          end
        end
      end
    end

    assign tree_sum = lvl[ADD_LVL].nd[0].sum_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            res <= '0;
    else if (vp_q[NV-2]) res <= tree_sum;
  end

  assign res_vld = vp_q[NV-1];

endmodule

// File: tb/tb_formula_isqrt_sum_pipe.sv
// Scoreboard bench for formula_isqrt_sum_pipe plus
// two extra parameterisations.
module tb_formula_isqrt_sum_pipe;

`ifdef FORMULA_ISQRT_SUM_IN_REG_EN
  localparam int EXT = 1;
`else
  localparam int EXT = 0;
`endif
  localparam int LAT  = 19 + EXT;
  localparam int LAT1 = 5 + EXT;
  localparam int LAT5 = 12 + EXT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arg_vld;
  logic [95:0] args;
  logic        res_vld;
  logic [17:0] res;
  logic        busy;

  logic        v1;
  logic [7:0]  a1;
  logic        rv1;
  logic [3:0]  r1;
  logic        b1;

  logic        v5;
  logic [79:0] a5;
  logic        rv5;
  logic [10:0] r5;
  logic        b5;

  formula_isqrt_sum_pipe #(.N_ARGS(3), .ARG_W(32)) dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .args(args),
    .res_vld(res_vld), .res(res), .busy(busy)
  );

  formula_isqrt_sum_pipe #(.N_ARGS(1), .ARG_W(8)) dut1 (
    .clk(clk), .rst(rst), .arg_vld(v1), .args(a1),
    .res_vld(rv1), .res(r1), .busy(b1)
  );

  formula_isqrt_sum_pipe #(.N_ARGS(5), .ARG_W(16)) dut5 (
    .clk(clk), .rst(rst), .arg_vld(v5), .args(a5),
    .res_vld(rv5), .res(r5), .busy(b5)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint val;
    int     due;
  } exp_t;

  exp_t   q[$];
  exp_t   me;
  int     ntests = 0;
  int     nfail  = 0;
  longint exp_hold = 0;
  int     k;

  task automatic chk(string tag, longint obs, longint exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic longint isq(longint x);
    longint lo = 0;
    longint hi = 65536;
    longint mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  task automatic drive(bit v, logic [31:0] x0,
                       logic [31:0] x1, logic [31:0] x2);
    exp_t e;
    @(posedge clk);
    #1;
    arg_vld = v;
    if (v) begin
      args  = {x2, x1, x0};
      e.val = isq(x0) + isq(x1) + isq(x2);
      e.due = cyc + LAT;
      q.push_back(e);
    end else begin
      args = 'x;
    end
  endtask

  task automatic sweep(logic [7:0] x1, logic [79:0] x5,
                       longint e1, longint e5);
    int st;
    int g1 = -1;
    int g5 = -1;
    longint gr1 = -1;
    longint gr5 = -1;
    @(posedge clk);
    #1;
    v1 = 1'b1;
    a1 = x1;
    v5 = 1'b1;
    a5 = x5;
    st = cyc;
    @(posedge clk);
    #1;
    v1 = 1'b0;
    a1 = 'x;
    v5 = 1'b0;
    a5 = 'x;
    repeat (30) begin
      @(negedge clk);
      if (rv1) begin g1 = cyc; gr1 = r1; end
      if (rv5) begin g5 = cyc; gr5 = r5; end
    end
    chk("n1_cycle", g1, st + LAT1);
    chk("n1_res", gr1, e1);
    chk("n5_cycle", g5, st + LAT5);
    chk("n5_res", gr5, e5);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (res_vld) begin
        if (q.size() == 0) begin
          chk("spurious_vld", res_vld, 0);
        end else begin
          me = q.pop_front();
          chk("res", res, me.val);
          chk("res_cycle", cyc, me.due);
          exp_hold = me.val;
        end
      end else begin
        chk("res_hold", res, exp_hold);
        if (q.size() > 0 && q[0].due < cyc) begin
          chk("missing_vld", res_vld, 1);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    arg_vld = 1'b0;
    args    = 'x;
    v1      = 1'b0;
    a1      = 'x;
    v5      = 1'b0;
    a5      = 'x;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_vld", res_vld, 0);
    chk("rst_res", res, 0);
    chk("rst_busy", busy, 0);
    chk("rst_busy_n1", b1, 0);
    chk("rst_busy_n5", b5, 0);
    @(negedge clk);
    rst = 1'b1;

    repeat (30) begin
      @(negedge clk);
      chk("idle_vld", res_vld, 0);
      chk("idle_res", res, 0);
      chk("idle_busy", busy, 0);
    end

    drive(1, 16, 25, 36);
    k = cyc;
    drive(0, 0, 0, 0);
    repeat (LAT + 2) begin
      @(negedge clk);
      chk("busy_window", busy,
          longint'((cyc - k >= 1) && (cyc - k <= LAT)));
    end
    chk("single_drained", q.size(), 0);

    drive(1, 0, 1, 3);
    drive(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drive(1, 15, 16, 17);
    drive(1, 2, 65536, 32'hFFFE_0001);
    drive(0, 0, 0, 0);
    repeat (LAT + 3) @(negedge clk);
    chk("bound_drained", q.size(), 0);

    repeat (100) drive(1, $urandom, $urandom, $urandom);
    drive(1, $urandom, $urandom, $urandom);
    drive(0, 0, 0, 0);
    drive(1, $urandom, $urandom, $urandom);
    drive(1, $urandom, $urandom, $urandom);
    drive(0, 0, 0, 0);
    repeat (LAT + 5) @(negedge clk);
    chk("stream_drained", q.size(), 0);

    drive(1, 49, 81, 121);
    k = cyc;
    repeat (4) drive(1, $urandom, $urandom, $urandom);
    drive(0, 0, 0, 0);
    while (cyc < k + 8) @(posedge clk);
    #3;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_vld", res_vld, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_res", res, 0);
    q.delete();
    exp_hold = 0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (LAT + 5) @(negedge clk);
    chk("flushed_idle_busy", busy, 0);
    drive(1, 100, 10000, 32'h4000_0000);
    drive(0, 0, 0, 0);
    repeat (LAT + 3) @(negedge clk);
    chk("post_rst_drained", q.size(), 0);
    chk("post_rst_res", res, 10 + 100 + 32768);

    sweep(8'hFF, {5{16'hFFFF}}, 15, 1275);
    sweep(8'd144, {16'hFFFF, 16'd4, 16'd3, 16'd1, 16'd0}, 12, 259);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
